// File: rtl/pll_phase_stepper.sv
// pll_phase_stepper: sequences PLL dynamic phase-shift pulses per request and tracks signed per-channel positions.
module pll_phase_stepper #(
    parameter int NUM_CH     = 3,
    parameter int STEP_W     = 8,
    parameter int POS_W      = 10,
    parameter int PULSE_CYC  = 2,
    parameter int SETTLE_CYC = 16,
    parameter int LOCK_TO    = 1024
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      req_valid,
    output logic                      req_ready,
    input  logic [2:0]                req_ch,
    input  logic                      req_dir,
    input  logic [STEP_W-1:0]         req_steps,
    input  logic                      pll_lock,
    output logic [2:0]                phase_sel,
    output logic                      phase_dir,
    output logic                      phase_step_n,
    output logic                      busy,
    output logic                      done,
    output logic                      err,
    output logic [NUM_CH*POS_W-1:0]   pos_flat
);
    localparam int TW = $clog2(LOCK_TO + PULSE_CYC + SETTLE_CYC + 1) + 1;
    typedef enum logic [2:0] {IDLE, SETUP, PULSE, GAP, LOCKWAIT} state_t;
    state_t state, state_n;
    logic [STEP_W-1:0] rem;
    logic [TW-1:0] tmr;
    logic step, accept, done_n, err_n;
    always_comb begin
        state_n = state;
        done_n  = 1'b0;
        err_n   = 1'b0;
        step    = 1'b0;
        accept  = 1'b0;
        case (state)
            IDLE:
                if (req_valid) begin
                    if (32'(req_ch) >= NUM_CH) err_n = 1'b1;
                    else if (req_steps == '0) done_n = 1'b1;
                    else begin
                        accept  = 1'b1;
                        state_n = SETUP;
                    end
                end
            SETUP: state_n = PULSE;
            PULSE:
                if (!pll_lock) begin
                    err_n   = 1'b1;
                    state_n = IDLE;
                end else if (tmr == TW'(PULSE_CYC - 1)) begin
                    step    = 1'b1;
                    state_n = GAP;
                end
            GAP:
                if (!pll_lock) begin
                    err_n   = 1'b1;
                    state_n = IDLE;
                end else if (tmr == TW'(SETTLE_CYC - 1)) begin
                    state_n = (rem == '0) ? LOCKWAIT : PULSE;
                end
            LOCKWAIT:
                if (pll_lock) begin
                    done_n  = 1'b1;
                    state_n = IDLE;
                end else if (tmr == TW'(LOCK_TO)) begin
                    err_n   = 1'b1;
                    state_n = IDLE;
                end
            default: state_n = IDLE;
        endcase
    end
    // tmr counts cycles spent in the current state and restarts on every transition
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            rem          <= '0;
            tmr          <= '0;
            req_ready    <= 1'b1;
            busy         <= 1'b0;
            done         <= 1'b0;
            err          <= 1'b0;
            phase_step_n <= 1'b1;
            phase_sel    <= '0;
            phase_dir    <= 1'b0;
            pos_flat     <= '0;
        end else begin
            state        <= state_n;
            tmr          <= (state_n != state) ? '0 : tmr + 1'b1;
            req_ready    <= state_n == IDLE;
            busy         <= state_n != IDLE;
            phase_step_n <= state_n != PULSE;
            done         <= done_n;
            err          <= err_n;
            if (accept) begin
                phase_sel <= req_ch;
                phase_dir <= req_dir;
                rem       <= req_steps;
            end
            if (step) rem <= rem - 1'b1;
            for (int k = 0; k < NUM_CH; k++)
                if (step && phase_sel == 3'(k))
                    pos_flat[k*POS_W +: POS_W] <= pos_flat[k*POS_W +: POS_W] + (phase_dir ? POS_W'(1) : {POS_W{1'b1}});
        end
    end
endmodule

// File: tb/tb_pll_phase_stepper.sv
// tb_pll_phase_stepper: directed requests with a response scoreboard checked by a separate monitor.
module tb_pll_phase_stepper;
    localparam int SETTLE = 16;
    logic clk = 1'b0, rst = 1'b1;
    logic req_valid = 1'b0, req_dir = 1'b0, pll_lock = 1'b1;
    logic [2:0] req_ch = '0;
    logic [7:0] req_steps = '0;
    logic req_ready, phase_dir, phase_step_n, busy, done, err;
    logic [2:0] phase_sel;
    logic [29:0] pos_flat;
    typedef struct {
        bit          is_err;
        int          lat;
        int          lows;
        int          sel;
        int          dir;
        logic [29:0] pos;
    } exp_t;
    exp_t q[$];
    exp_t e;
    logic [29:0] exp_pos;
    int n_cmp = 0, n_bad = 0, cyc = 0, acc = 0, lows = 0;

    pll_phase_stepper dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_ch(req_ch), .req_dir(req_dir), .req_steps(req_steps), .pll_lock(pll_lock),
        .phase_sel(phase_sel), .phase_dir(phase_dir), .phase_step_n(phase_step_n),
        .busy(busy), .done(done), .err(err), .pos_flat(pos_flat)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic void push(input bit is_err, input int lat, input int lw, input int sel, input int dir, input logic [29:0] pos);
        q.push_back('{is_err, lat, lw, sel, dir, pos});
    endfunction

    always @(posedge clk) begin
        cyc++;
        if (req_valid && req_ready) acc = cyc;
    end

    // monitor: pops one expectation per done/err pulse
    always @(negedge clk) begin
        if (rst) lows = 0;
        else begin
            if (!phase_step_n) lows++;
            if (done || err) begin
                if (q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_resp: got done=%0b err=%0b expected no response", done, err);
                end else begin
                    e = q.pop_front();
                    chk("resp_err", err, e.is_err);
                    chk("resp_done", done, !e.is_err);
                    if (e.lat >= 0) chk("latency", cyc - acc, e.lat);
                    chk("low_cycles", lows, e.lows);
                    if (e.sel >= 0) chk("phase_sel", phase_sel, e.sel);
                    if (e.dir >= 0) chk("phase_dir", phase_dir, e.dir);
                    chk("pos_flat", pos_flat, e.pos);
                end
                lows = 0;
            end
        end
    end

    task automatic issue(input logic [2:0] ch, input logic d, input logic [7:0] s);
        int t = 0;
        @(negedge clk);
        while (!req_ready && t < 5000) begin
            @(negedge clk);
            t++;
        end
        chk("ready_before_req", req_ready, 1);
        req_valid = 1'b1;
        req_ch    = ch;
        req_dir   = d;
        req_steps = s;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        req_ch    = ~ch;
        req_dir   = ~d;
        req_steps = 8'hA5;
    endtask

    task automatic drain(input int budget);
        int t = 0;
        while (q.size() != 0 && t < budget) begin
            @(negedge clk);
            t++;
        end
        chk("drain_pending", q.size(), 0);
    endtask

    task automatic wait_pulses(input int n);
        int seen = 0;
        logic p = phase_step_n;
        for (int t = 0; t < 2000 && seen < n; t++) begin
            @(posedge clk);
            #1;
            if (phase_step_n && !p) seen++;
            p = phase_step_n;
        end
        chk("pulse_wait", seen, n);
    endtask

    initial begin
        #1000000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1);
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ready", req_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        chk("rst_step_n", phase_step_n, 1);
        chk("rst_sel", phase_sel, 0);
        chk("rst_dir", phase_dir, 0);
        chk("rst_pos", pos_flat, 0);
        @(negedge clk);
        rst = 1'b0;
        exp_pos = '0;
        exp_pos[19:10] = 10'd3;
        push(0, 56, 6, 1, 1, exp_pos);
        issue(3'd1, 1'b1, 8'd3);
        drain(200);
        push(1, -1, 0, -1, -1, exp_pos);
        issue(3'd5, 1'b1, 8'd4);
        drain(10);
        push(0, -1, 0, -1, -1, exp_pos);
        issue(3'd0, 1'b1, 8'd0);
        drain(10);
        exp_pos[29:20] = 10'h3FE;
        push(1, 27, 4, 2, 0, exp_pos);
        issue(3'd2, 1'b0, 8'd5);
        wait_pulses(2);
        repeat (5) @(posedge clk);
        #1 pll_lock = 1'b0;
        drain(50);
        pll_lock = 1'b1;
        exp_pos[9:0] = 10'd1;
        push(1, 1044, 2, 0, 1, exp_pos);
        issue(3'd0, 1'b1, 8'd1);
        wait_pulses(1);
        repeat (SETTLE) @(posedge clk);
        #1 pll_lock = 1'b0;
        drain(1200);
        pll_lock = 1'b1;
        issue(3'd0, 1'b1, 8'd4);
        for (int t = 0; t < 20 && phase_step_n; t++) begin
            @(posedge clk);
            #1;
        end
        chk("pulse_started", phase_step_n, 0);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("mid_rst_step_n", phase_step_n, 1);
        chk("mid_rst_ready", req_ready, 1);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_pos", pos_flat, 0);
        @(negedge clk);
        #1 rst = 1'b0;
        repeat (40) @(negedge clk);
        chk("mid_rst_idle_pos", pos_flat, 0);
        exp_pos = '0;
        for (int i = 1; i <= 512; i++) begin
            exp_pos[9:0] = 10'(i);
            push(0, 20, 2, 0, 1, exp_pos);
            issue(3'd0, 1'b1, 8'd1);
            drain(100);
        end
        chk("wrap_pos", pos_flat[9:0], 10'h200);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
